// File: rtl/fifo_scoreboard_checker.sv
// Cycle-accurate reference model of a synchronous FIFO. It compares the DUT's
// outputs every cycle and accumulates pass/fail statistics and first-failure capture.
module fifo_scoreboard_checker #(
  parameter int         DATA_WIDTH = 16,
  parameter int         DEPTH      = 8,
  parameter int         CNT_WIDTH  = 16,
  parameter int         NUM_CHECKS = 1000,
  parameter int         ERR_LIMIT  = 1,
  parameter logic [6:0] CHECK_MASK = 7'h7F
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clear_i,
  input  logic                  check_en_i,
  input  logic                  wr_en_i,
  input  logic                  rd_en_i,
  input  logic [DATA_WIDTH-1:0] data_in_i,
  input  logic [DATA_WIDTH-1:0] data_out_i,
  input  logic                  wr_ack_i,
  input  logic                  full_i,
  input  logic                  empty_i,
  input  logic                  almostfull_i,
  input  logic                  almostempty_i,
  input  logic                  overflow_i,
  input  logic                  underflow_i,
  output logic [CNT_WIDTH-1:0]  correct_count_o,
  output logic [CNT_WIDTH-1:0]  error_count_o,
  output logic [7:0]            err_flags_o,
  output logic [CNT_WIDTH-1:0]  first_err_cycle_o,
  output logic                  mismatch_o,
  output logic                  done_o
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);
  localparam logic [CW-1:0]        CNT_FULL     = CW'(DEPTH);
  localparam logic [CW-1:0]        CNT_AF       = CW'(DEPTH - 1);
  localparam logic [PW-1:0]        PTR_LAST     = PW'(DEPTH - 1);
  localparam logic [CNT_WIDTH:0]   NUM_CHECKS_W = (CNT_WIDTH+1)'(NUM_CHECKS);
  localparam logic [CNT_WIDTH:0]   ERR_LIMIT_W  = (CNT_WIDTH+1)'(ERR_LIMIT);

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (&v) ? v : v + CNT_WIDTH'(1);
  endfunction

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [CW-1:0]         count_q, count_d;
  logic [PW-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic                  exp_wr_ack_q, exp_wr_ack_d, exp_ovf_q, exp_ovf_d, exp_unf_q, exp_unf_d;
  logic [DATA_WIDTH-1:0] exp_data_q, exp_data_d;
  logic                  data_vld_q, data_vld_d, cmp_vld_q, cmp_vld_d;
  logic [CNT_WIDTH-1:0]  correct_q, correct_d, error_q, error_d, cycle_q, cycle_d, first_q, first_d;
  logic [7:0]            flags_q, flags_d;
  logic                  mismatch_q, mismatch_d, done_q, done_d;

  logic       full_exp, empty_exp, wa, ra, any_mis, cmp_act;
  logic [6:0] exp_vec, obs_vec;
  logic [7:0] mis_vec;

  always_comb begin
    full_exp  = (count_q == CNT_FULL);
    empty_exp = (count_q == '0);
    wa        = wr_en_i && !full_exp;
    ra        = rd_en_i && !empty_exp;
    exp_vec   = {exp_unf_q, exp_ovf_q, count_q == CW'(1), count_q == CNT_AF,
                 empty_exp, full_exp, exp_wr_ack_q};
    obs_vec   = {underflow_i, overflow_i, almostempty_i, almostfull_i,
                 empty_i, full_i, wr_ack_i};
    // Read data is meaningless until the model has performed its first read.
    mis_vec   = {data_vld_q && (data_out_i != exp_data_q), (obs_vec ^ exp_vec) & CHECK_MASK};
    any_mis   = |mis_vec;
    cmp_act   = cmp_vld_q && !done_q;
  end

  always_comb begin
    count_d      = count_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    exp_wr_ack_d = exp_wr_ack_q;
    exp_ovf_d    = exp_ovf_q;
    exp_unf_d    = exp_unf_q;
    exp_data_d   = exp_data_q;
    data_vld_d   = data_vld_q;
    correct_d    = correct_q;
    error_d      = error_q;
    cycle_d      = cycle_q;
    first_d      = first_q;
    flags_d      = flags_q;
    done_d       = done_q;
    mismatch_d   = 1'b0;
    cmp_vld_d    = check_en_i && !done_q;
    if (clear_i) begin
      count_d      = '0;
      wr_ptr_d     = '0;
      rd_ptr_d     = '0;
      exp_wr_ack_d = 1'b0;
      exp_ovf_d    = 1'b0;
      exp_unf_d    = 1'b0;
      exp_data_d   = '0;
      data_vld_d   = 1'b0;
      correct_d    = '0;
      error_d      = '0;
      cycle_d      = '0;
      first_d      = '0;
      flags_d      = '0;
      done_d       = 1'b0;
      cmp_vld_d    = 1'b0;
    end else begin
      if (!done_q) begin
        exp_wr_ack_d = wa;
        exp_ovf_d    = wr_en_i && full_exp;
        exp_unf_d    = rd_en_i && empty_exp;
        if (wa) wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + PW'(1);
        if (ra) begin
          rd_ptr_d   = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + PW'(1);
          exp_data_d = mem_q[rd_ptr_q];
          data_vld_d = 1'b1;
        end
        if (wa && !ra)      count_d = count_q + CW'(1);
        else if (ra && !wa) count_d = count_q - CW'(1);
      end
      if (cmp_act) begin
        cycle_d = sat_inc(cycle_q);
        if (any_mis) begin
          error_d    = sat_inc(error_q);
          flags_d    = flags_q | mis_vec;
          mismatch_d = 1'b1;
          if (error_q == '0) first_d = cycle_q;
          if (ERR_LIMIT != 0 && ({1'b0, error_q} + (CNT_WIDTH+1)'(1)) == ERR_LIMIT_W) done_d = 1'b1;
        end else begin
          correct_d = sat_inc(correct_q);
        end
        if (NUM_CHECKS != 0 && ({1'b0, cycle_q} + (CNT_WIDTH+1)'(1)) == NUM_CHECKS_W) done_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!clear_i && !done_q && wa) mem_q[wr_ptr_q] <= data_in_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q      <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      exp_wr_ack_q <= 1'b0;
      exp_ovf_q    <= 1'b0;
      exp_unf_q    <= 1'b0;
      exp_data_q   <= '0;
      data_vld_q   <= 1'b0;
      cmp_vld_q    <= 1'b0;
      correct_q    <= '0;
      error_q      <= '0;
      cycle_q      <= '0;
      first_q      <= '0;
      flags_q      <= '0;
      mismatch_q   <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      count_q      <= count_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      exp_wr_ack_q <= exp_wr_ack_d;
      exp_ovf_q    <= exp_ovf_d;
      exp_unf_q    <= exp_unf_d;
      exp_data_q   <= exp_data_d;
      data_vld_q   <= data_vld_d;
      cmp_vld_q    <= cmp_vld_d;
      correct_q    <= correct_d;
      error_q      <= error_d;
      cycle_q      <= cycle_d;
      first_q      <= first_d;
      flags_q      <= flags_d;
      mismatch_q   <= mismatch_d;
      done_q       <= done_d;
    end
  end

  assign correct_count_o   = correct_q;
  assign error_count_o     = error_q;
  assign err_flags_o       = flags_q;
  assign first_err_cycle_o = first_q;
  assign mismatch_o        = mismatch_q;
  assign done_o            = done_q;
endmodule

// File: tb/tb_fifo_scoreboard_checker.sv
// Bench: a queue-based FIFO stands in for the DUT, with optional output faults;
// the checker's statistics are predicted from the injected fault schedule.
module tb_fifo_scoreboard_checker;
  localparam int DW = 16, D = 5, CNTW = 16, NCHK = 200, ELIM = 3;
  localparam logic [6:0] MASK = 7'h77;

  logic clk = 1'b0, rst_n = 1'b0, clear = 1'b0, check_en = 1'b0, wr_en = 1'b0, rd_en = 1'b0;
  logic [DW-1:0] data_in = '0, data_out = '0;
  logic wr_ack = 1'b0, full = 1'b0, empty = 1'b0, almostfull = 1'b0;
  logic almostempty = 1'b0, overflow = 1'b0, underflow = 1'b0;
  logic [CNTW-1:0] correct_count, error_count, first_err_cycle;
  logic [7:0] err_flags;
  logic mismatch, done;

  fifo_scoreboard_checker #(
    .DATA_WIDTH(DW), .DEPTH(D), .CNT_WIDTH(CNTW), .NUM_CHECKS(NCHK),
    .ERR_LIMIT(ELIM), .CHECK_MASK(MASK)
  ) dut (
    .clk(clk), .rst_n(rst_n), .clear_i(clear), .check_en_i(check_en),
    .wr_en_i(wr_en), .rd_en_i(rd_en), .data_in_i(data_in), .data_out_i(data_out),
    .wr_ack_i(wr_ack), .full_i(full), .empty_i(empty), .almostfull_i(almostfull),
    .almostempty_i(almostempty), .overflow_i(overflow), .underflow_i(underflow),
    .correct_count_o(correct_count), .error_count_o(error_count), .err_flags_o(err_flags),
    .first_err_cycle_o(first_err_cycle), .mismatch_o(mismatch), .done_o(done)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_pass = 0;

  // Golden FIFO standing in for the device being checked
  logic [DW-1:0] gq[$];
  logic g_ack = 1'b0, g_ovf = 1'b0, g_unf = 1'b0, g_dvld = 1'b0;
  logic [DW-1:0] g_dout = '0;

  // Expected checker statistics
  int m_ok = 0, m_err = 0, m_cyc = 0, m_first = 0;
  logic [7:0] m_flags = '0;
  logic m_mis = 1'b0, m_done = 1'b0, prev_ce = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  task automatic model_clear();
    m_ok = 0; m_err = 0; m_cyc = 0; m_first = 0; m_flags = '0;
    m_mis = 1'b0; m_done = 1'b0; prev_ce = 1'b0;
    gq.delete();
    g_ack = 1'b0; g_ovf = 1'b0; g_unf = 1'b0; g_dvld = 1'b0; g_dout = '0;
  endtask

  task automatic golden_step(input logic we, input logic re, input logic [DW-1:0] din);
    int sz;
    sz = gq.size();
    g_ack = we && (sz != D);
    g_ovf = we && (sz == D);
    g_unf = re && (sz == 0);
    if (re && sz != 0) begin
      g_dout = gq.pop_front();
      g_dvld = 1'b1;
    end
    if (we && sz != D) gq.push_back(din);
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, " correct_count"}, 32'(correct_count), 32'(m_ok));
    chk({tag, " error_count"}, 32'(error_count), 32'(m_err));
    chk({tag, " err_flags"}, 32'(err_flags), 32'(m_flags));
    chk({tag, " first_err_cycle"}, 32'(first_err_cycle), 32'(m_first));
    chk({tag, " mismatch"}, 32'(mismatch), 32'(m_mis));
    chk({tag, " done"}, 32'(done), 32'(m_done));
  endtask

  // One clock: present the golden outputs (with faults), then predict the edge.
  task automatic step(input logic we, input logic re, input logic [DW-1:0] din,
                      input logic ce, input logic clr, input logic [7:0] fault, input string tag);
    logic [7:0] fb;
    logic cmp, bad;
    int sz;
    @(negedge clk);
    wr_en = we; rd_en = re; data_in = din; check_en = ce; clear = clr;
    sz = gq.size();
    {underflow, overflow, almostempty, almostfull, empty, full, wr_ack} =
      {g_unf, g_ovf, sz == 1, sz == D - 1, sz == 0, sz == D, g_ack} ^ fault[6:0];
    data_out = g_dout ^ DW'(fault[7]);
    @(posedge clk);
    if (clr) begin
      model_clear();
    end else begin
      cmp = prev_ce && !m_done;
      fb  = {fault[7] & g_dvld, fault[6:0] & MASK};
      bad = |fb;
      m_mis = cmp && bad;
      if (cmp) begin
        if (bad) begin
          if (m_err == 0) m_first = m_cyc;
          if (m_err + 1 == ELIM) m_done = 1'b1;
          m_err++;
          m_flags |= fb;
        end else begin
          m_ok++;
        end
        if (m_cyc + 1 == NCHK) m_done = 1'b1;
        m_cyc++;
      end
      prev_ce = ce;
      golden_step(we, re, din);
    end
    #1 check_outputs(tag);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 model_clear();
    check_outputs("async_reset");
    wr_en = 1'b0; rd_en = 1'b0; check_en = 1'b0; clear = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1 check_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Directed: fill, overflow, both-at-full, drain, underflow, both-at-3
    for (int i = 1; i <= D; i++) step(1'b1, 1'b0, DW'(i), 1'b1, 1'b0, 8'h00, "fill");
    step(1'b1, 1'b0, 16'hBEEF, 1'b1, 1'b0, 8'h00, "overflow");
    step(1'b1, 1'b1, 16'h0A0A, 1'b1, 1'b0, 8'h00, "both_full");
    for (int i = 0; i < D; i++) step(1'b0, 1'b1, '0, 1'b1, 1'b0, 8'h00, "drain");
    step(1'b0, 1'b1, '0, 1'b1, 1'b0, 8'h00, "underflow");
    step(1'b1, 1'b1, 16'h0055, 1'b1, 1'b0, 8'h00, "both_empty");
    for (int i = 0; i < 2; i++) step(1'b1, 1'b0, DW'(16'h100 + i), 1'b1, 1'b0, 8'h00, "to3");
    step(1'b1, 1'b1, 16'h0777, 1'b1, 1'b0, 8'h00, "both_3");
    step(1'b0, 1'b1, '0, 1'b1, 1'b0, 8'h00, "read");
    step(1'b0, 1'b0, '0, 1'b1, 1'b0, 8'h80, "data_flip");
    step(1'b0, 1'b0, '0, 1'b1, 1'b0, 8'h08, "masked_flip");
    step(1'b0, 1'b0, '0, 1'b0, 1'b0, 8'h00, "idle");
    step(1'b0, 1'b0, '0, 1'b1, 1'b0, 8'h02, "no_cmp_flip");
    step(1'b0, 1'b0, '0, 1'b1, 1'b0, 8'h40, "unf_flip");

    // Randomized rounds: first fault-free until NUM_CHECKS, later ones reach ERR_LIMIT
    for (int r = 0; r < 4; r++) begin
      step(1'b0, 1'b0, '0, 1'b0, 1'b1, 8'h00, "clear");
      for (int i = 0; i < ((r == 0) ? 260 : 150); i++) begin
        logic we, re, ce;
        logic [7:0] f;
        we = $urandom_range(0, 99) < ((r % 2) ? 70 : 45);
        re = $urandom_range(0, 99) < ((r % 2) ? 45 : 60);
        ce = $urandom_range(0, 7) != 0;
        f  = (r != 0 && $urandom_range(0, 19) == 0) ? 8'(1 << $urandom_range(0, 7)) : 8'h00;
        step(we, re, DW'($urandom), ce, 1'b0, f, "rand");
      end
    end

    // Reset mid-stream at count 4, fault on the uncompared first cycle, then clear
    step(1'b0, 1'b0, '0, 1'b0, 1'b1, 8'h00, "clear2");
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, DW'(16'h200 + i), 1'b1, 1'b0, 8'h00, "pre_rst");
    do_reset();
    step(1'b0, 1'b0, '0, 1'b1, 1'b0, 8'h01, "post_rst");
    step(1'b1, 1'b0, 16'h0042, 1'b1, 1'b0, 8'h00, "post_rst_wr");
    step(1'b0, 1'b0, '0, 1'b1, 1'b1, 8'h00, "clear3");
    step(1'b0, 1'b0, '0, 1'b1, 1'b0, 8'h04, "post_clr");
    step(1'b0, 1'b1, '0, 1'b1, 1'b0, 8'h00, "post_clr_rd");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
